spi_master_mode: RTL and testbench
==================================

SPI_MASTER_MODE -- requirements
Module: spi_master_mode

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per word (4..32).
REQ-002 SHALL have parameter CLK_DIV, default 8, meaning clk cycles per SCLK half-period (>=2).
REQ-003 SHALL have parameter CS_NUM, default 1, meaning chip-select count (1..8).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  transfer request; accepted when req&ready.
REQ-007 ready  output  1  high in IDLE and HOLD.
REQ-008 din  input  DATA_W  transmit word, MSB first.
REQ-009 cpol  input  1  SCLK idle level.
REQ-010 cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-011 cs_sel  input  $clog2(CS_NUM) (min 1)  target slave index.
REQ-012 hold  input  1  keep CS asserted after this word.
REQ-013 release  input  1  end a held burst without data.
REQ-014 done  output  1  one-cycle pulse, word complete.
REQ-015 dout  output  DATA_W  received word, valid while done is high and held until the next done.
REQ-016 spi_sclk  output  1; spi_mosi  output  1; spi_miso  input  1; spi_cs_n  output  CS_NUM, active low.

Function
REQ-017 On accept SHALL latch din, cpol, cpha, cs_sel and hold; din, cpol, cpha and cs_sel are ignored at all other times.
REQ-018 States SHALL be IDLE, SETUP, XFER, HOLD, TRAIL.
REQ-019 IDLE->SETUP on accept; SETUP asserts spi_cs_n[cs_sel] low, keeps SCLK=cpol, and lasts CLK_DIV cycles, then ->XFER.
REQ-020 XFER SHALL produce 2*DATA_W SCLK edges, one every CLK_DIV cycles, first edge CLK_DIV cycles after XFER entry.
REQ-021 cpha=0: MOSI SHALL present the MSB from accept+1 cycle, sample MISO on odd edges (1,3,...), and shift MOSI on even edges except the last.
REQ-022 cpha=1: MOSI SHALL shift out on odd edges (MSB at edge 1) and sample MISO on even edges.
REQ-023 After edge 2*DATA_W, SHALL pulse done in the next cycle with dout updated, then ->HOLD if hold was latched, else ->TRAIL.
REQ-024 Accept-to-done latency SHALL be (2*DATA_W+1)*CLK_DIV+1 cycles from IDLE, and 2*DATA_W*CLK_DIV+1 cycles from HOLD.
REQ-025 HOLD: CS stays asserted; accept ->XFER directly (no SETUP); release ->TRAIL.
REQ-026 In HOLD, a req with a cs_sel different from the latched index SHALL NOT be accepted; ready is low in that case.
REQ-027 Simultaneous req and release in HOLD SHALL take req; release is ignored outside HOLD.
REQ-028 TRAIL: CS stays asserted for CLK_DIV cycles, then all spi_cs_n go high and the state ->IDLE.
REQ-029 Between transfers SCLK SHALL rest at the latched cpol; cpol changes take effect only at an accept from IDLE.
REQ-030 Bit and divider counters SHALL wrap to 0 exactly at their terminal counts; no extra SCLK edge is produced.

Reset
REQ-031 Asynchronous reset SHALL force IDLE, ready=1, done=0, dout=0, spi_sclk=0, spi_mosi=0, spi_cs_n all ones, and latched cpol=0.
REQ-032 Reset mid-transfer SHALL deassert CS immediately, and no done SHALL follow.

Structure
REQ-033 A shared package spi_pkg SHALL hold the state encoding, the default DATA_W/CLK_DIV values, and the mode constants (MODE0..MODE3 = {cpol,cpha}).
REQ-034 A sub-module spi_clk_gen SHALL contain the divider counter, edge count and edge strobes (lead, trail, last).

Verification
REQ-035 Mode 0, DATA_W=8, CLK_DIV=4, din=0xA5, MISO looped back -> 16 SCLK edges, dout=0xA5, done at accept+69 cycles.
REQ-036 Mode 3, din=0x3C, MISO tied to a slave returning 0xC3 -> SCLK idles high, dout=0xC3, MOSI stream 0,0,1,1,1,1,0,0.
REQ-037 hold=1 for 3 words 0x11,0x22,0x33 to cs_sel=2, last with hold=0 -> spi_cs_n[2] low continuously and 3 done pulses.
REQ-038 HOLD then release -> CS high CLK_DIV cycles later, no done, ready stays high.
REQ-039 rst_n low at edge 5 of a transfer -> CS high asynchronously, no done, next transfer is correct.
REQ-040 In HOLD, req with a different cs_sel -> not accepted until release completes TRAIL.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_pkg                                                    |
// | Brief   : Shared state encoding, defaults and SPI mode constants.    |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 8;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_TRAIL = 3'd4
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_clk_gen                                                |
// | Brief   : SCLK divider and edge counter producing lead/trail/last.   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic edge_en,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic last
);

  localparam int c_div_w  = $clog2(CLK_DIV);
  localparam int c_edge_w = $clog2(2 * DATA_W);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [c_edge_w-1:0] c_edge_last = c_edge_w'(2 * DATA_W - 1);

  logic [c_div_w-1:0]  r_div;
  logic [c_edge_w-1:0] r_edge;
  logic                w_edge;

  assign tick   = run && (r_div == c_div_last);
  assign w_edge = tick && edge_en;
  // Edge index 0 is SCLK edge 1, so even indices are leading edges.
  assign lead   = w_edge && !r_edge[0];
  assign trail  = w_edge && r_edge[0];
  assign last   = trail && (r_edge == c_edge_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_edge <= '0;
    end else begin
      if (run)
        r_div <= tick ? '0 : r_div + 1'b1;
      if (w_edge)
        r_edge <= last ? '0 : r_edge + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_mode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_master_mode                                            |
// | Brief   : SPI master, all four modes, multi-CS with held bursts.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_master_mode
  import spi_pkg::*;
#(
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  CLK_DIV = DEF_CLK_DIV,
  parameter int  CS_NUM  = 1,
  localparam int CS_W    = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold,
  input  logic              release_burst,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [CS_NUM-1:0] spi_cs_n
);

  spi_state_e        r_state;
  spi_state_e        w_next;
  logic              r_cpha;
  logic              r_hold;
  logic              r_fin;
  logic              r_done;
  logic              r_sclk;
  logic              r_mosi;
  logic [CS_W-1:0]   r_cs;
  logic [CS_NUM-1:0] r_cs_n;
  logic [CS_NUM-1:0] w_cs_n_sel;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_dout;
  logic              w_ready;
  logic              w_accept;
  logic              w_run;
  logic              w_edge_en;
  logic              w_tick;
  logic              w_lead;
  logic              w_trail;
  logic              w_last;
  logic              w_shift;
  logic              w_sample;

  // A held burst may only continue on the slave it already owns.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_HOLD: w_ready = !(req && (cs_sel != r_cs));
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept  = req && w_ready;
  assign w_edge_en = (r_state == ST_XFER) && !r_fin;
  assign w_run     = (r_state == ST_SETUP) || (r_state == ST_TRAIL) || w_edge_en;
  assign w_shift   = r_cpha ? w_lead : (w_trail && !w_last);
  assign w_sample  = r_cpha ? w_trail : w_lead;

  always_comb begin
    w_cs_n_sel = '1;
    for (int i = 0; i < CS_NUM; i++)
      if (cs_sel == CS_W'(i))
        w_cs_n_sel[i] = 1'b0;
  end

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_run),
    .edge_en (w_edge_en),
    .tick    (w_tick),
    .lead    (w_lead),
    .trail   (w_trail),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (w_tick) w_next = ST_XFER;
      ST_XFER:  if (r_fin) w_next = r_hold ? ST_HOLD : ST_TRAIL;
      ST_HOLD: begin
        if (w_accept)
          w_next = ST_XFER;
        else if (release_burst)
          w_next = ST_TRAIL;
      end
      ST_TRAIL: if (w_tick) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_sclk doubles as the latched cpol: 2*DATA_W toggles always bring it back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpha <= 1'b0;
      r_hold <= 1'b0;
      r_fin  <= 1'b0;
      r_done <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_cs   <= '0;
      r_cs_n <= '1;
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
    end else begin
      r_fin  <= w_last;
      r_done <= r_fin;
      if (r_fin)
        r_dout <= r_rx;
      if (w_lead || w_trail)
        r_sclk <= ~r_sclk;
      if (w_sample)
        r_rx <= {r_rx[DATA_W-2:0], spi_miso};
      if (w_shift) begin
        r_mosi <= r_tx[DATA_W-1];
        r_tx   <= r_tx << 1;
      end
      if (w_accept) begin
        r_cpha <= cpha;
        r_cs   <= cs_sel;
        r_hold <= hold;
        if (cpha) begin
          r_tx <= din;
        end else begin
          r_tx   <= din << 1;
          r_mosi <= din[DATA_W-1];
        end
        if (r_state == ST_IDLE) begin
          r_sclk <= cpol;
          r_cs_n <= w_cs_n_sel;
        end
      end
      if ((r_state == ST_TRAIL) && w_tick)
        r_cs_n <= '1;
    end
  end

  assign ready    = w_ready;
  assign done     = r_done;
  assign dout     = r_dout;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_master_mode                                         |
// | Brief   : Directed + random bench with a behavioural SPI slave.      |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spi_master_mode;
  import spi_pkg::*;

  localparam int DW       = 8;
  localparam int CD       = 4;
  localparam int CSN      = 4;
  localparam int LAT_IDLE = (2 * DW + 1) * CD + 1;
  localparam int LAT_HOLD = 2 * DW * CD + 1;

  logic           clk;
  logic           rst_n;
  logic           req;
  logic           ready;
  logic [DW-1:0]  din;
  logic           cpol;
  logic           cpha;
  logic [1:0]     cs_sel;
  logic           hold;
  logic           release_burst;
  logic           done;
  logic [DW-1:0]  dout;
  logic           spi_sclk;
  logic           spi_mosi;
  logic           spi_miso;
  logic [CSN-1:0] spi_cs_n;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int cs2_high  = 0;
  bit mon_cs2   = 0;

  // Behavioural slave: counts SCLK transitions of the armed transfer.
  bit            armed;
  bit            loopback;
  bit            m_cpha;
  logic [DW-1:0] s_word;
  logic [DW-1:0] s_rx;
  logic          s_miso;
  int            s_edges;
  int            s_idx;

  assign spi_miso = loopback ? spi_mosi : s_miso;

  spi_master_mode #(
    .DATA_W  (DW),
    .CLK_DIV (CD),
    .CS_NUM  (CSN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .ready         (ready),
    .din           (din),
    .cpol          (cpol),
    .cpha          (cpha),
    .cs_sel        (cs_sel),
    .hold          (hold),
    .release_burst (release_burst),
    .done          (done),
    .dout          (dout),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_cs_n      (spi_cs_n)
  );

  always #5 clk = ~clk;

  always @(spi_sclk) begin
    if (armed) begin
      s_edges++;
      if (((s_edges % 2) == 0) == m_cpha) begin
        s_rx = {s_rx[DW-2:0], spi_mosi};
      end else begin
        s_idx = m_cpha ? (s_edges - 1) / 2 : s_edges / 2;
        if (s_idx < DW)
          s_miso = s_word[DW-1-s_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1)
      done_cnt++;
    if (mon_cs2 && spi_cs_n[2] !== 1'b0)
      cs2_high++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic [DW-1:0] d, input int cs,
                       input bit hv, input bit rel);
    @(negedge clk);
    req           = 1'b1;
    din           = d;
    cpol          = mode[1];
    cpha          = mode[0];
    cs_sel        = 2'(cs);
    hold          = hv;
    release_burst = rel;
  endtask

  task automatic arm(input logic [1:0] mode, input logic [DW-1:0] sw, input bit lb);
    m_cpha   = mode[0];
    s_word   = sw;
    loopback = lb;
    s_edges  = 0;
    s_rx     = '0;
    s_miso   = sw[DW-1];
    armed    = 1'b1;
  endtask

  // Called #1 after the accepting edge; checks the whole word and CS tail.
  task automatic finish(input logic [1:0] mode, input logic [DW-1:0] d, input logic [DW-1:0] sw,
                        input int cs, input bit hv, input bit lb, input bit from_hold,
                        input string tag);
    int             lat;
    int             n;
    logic [CSN-1:0] ecs;
    ecs     = '1;
    ecs[cs] = 1'b0;
    chk({tag, "/sclk_idle"}, 32'(spi_sclk), 32'(mode[1]));
    if (!mode[0])
      chk({tag, "/mosi_msb"}, 32'(spi_mosi), 32'(d[DW-1]));
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1)
        break;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(from_hold ? LAT_HOLD : LAT_IDLE));
    chk({tag, "/dout"}, 32'(dout), 32'(lb ? d : sw));
    chk({tag, "/mosi_stream"}, 32'(s_rx), 32'(d));
    chk({tag, "/edges"}, 32'(s_edges), 32'(2 * DW));
    chk({tag, "/sclk_rest"}, 32'(spi_sclk), 32'(mode[1]));
    chk({tag, "/cs_n"}, 32'(spi_cs_n), 32'(ecs));
    armed = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, 32'(done), 32'd0);
    if (!hv) begin
      n = 1;
      while (spi_cs_n !== '1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk({tag, "/trail"}, 32'(n), 32'(CD));
    end
  endtask

  task automatic xfer(input logic [1:0] mode, input logic [DW-1:0] d, input logic [DW-1:0] sw,
                      input int cs, input bit hv, input bit lb, input bit from_hold,
                      input bit rel, input string tag);
    drive(mode, d, cs, hv, rel);
    #1 chk({tag, "/ready"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    req           = 1'b0;
    release_burst = 1'b0;
    arm(mode, sw, lb);
    finish(mode, d, sw, cs, hv, lb, from_hold, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    mode;
    logic [DW-1:0] d;
    logic [DW-1:0] sw;
    int            d0;
    int            n;
    clk = 0; rst_n = 0; req = 0; din = '0; cpol = 0; cpha = 0; cs_sel = '0;
    hold = 0; release_burst = 0; armed = 0; loopback = 0; m_cpha = 0;
    s_word = '0; s_rx = '0; s_miso = 0; s_edges = 0; s_idx = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", 32'(ready), 32'd1);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/dout", 32'(dout), 32'd0);
    chk("rst/sclk", 32'(spi_sclk), 32'd0);
    chk("rst/mosi", 32'(spi_mosi), 32'd0);
    chk("rst/cs_n", 32'(spi_cs_n), 32'hF);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    xfer(MODE0, 8'hA5, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, "mode0_loop");
    xfer(MODE3, 8'h3C, 8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b0, "mode3_slave");

    for (int i = 0; i < 6; i++) begin
      mode = 2'($urandom_range(0, 3));
      d    = DW'($urandom);
      sw   = DW'($urandom);
      xfer(mode, d, sw, int'($urandom_range(0, CSN - 1)), 1'b0,
           bit'($urandom_range(0, 1)), 1'b0, 1'b0, "random");
    end

    // Three-word held burst on cs 2.
    mode = 2'($urandom_range(0, 3));
    d0   = done_cnt;
    xfer(mode, 8'h11, DW'($urandom), 2, 1'b1, 1'b1, 1'b0, 1'b0, "burst0");
    cs2_high = 0;
    mon_cs2  = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("burst/hold_ready", 32'(ready), 32'd1);
    xfer(mode, 8'h22, DW'($urandom), 2, 1'b1, 1'b0, 1'b1, 1'b0, "burst1");
    xfer(mode, 8'h33, DW'($urandom), 2, 1'b0, 1'b0, 1'b1, 1'b0, "burst2");
    mon_cs2 = 1'b0;
    chk("burst/cs2_high_cycles", 32'(cs2_high), 32'd0);
    chk("burst/done_count", 32'(done_cnt - d0), 32'd3);

    // Hold then release without data.
    mode = 2'($urandom_range(0, 3));
    xfer(mode, DW'($urandom), DW'($urandom), 0, 1'b1, 1'b0, 1'b0, 1'b0, "rel0");
    repeat (3) @(posedge clk);
    #1 chk("rel/hold_ready", 32'(ready), 32'd1);
    chk("rel/hold_cs", 32'(spi_cs_n), 32'hE);
    d0 = done_cnt;
    @(negedge clk) release_burst = 1'b1;
    @(posedge clk); #1;
    release_burst = 1'b0;
    n = 0;
    while (spi_cs_n !== '1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rel/cs_high_delay", 32'(n), 32'(CD));
    chk("rel/no_done", 32'(done_cnt - d0), 32'd0);
    chk("rel/idle_ready", 32'(ready), 32'd1);

    // Simultaneous req and release in HOLD: the request wins.
    mode = 2'($urandom_range(0, 3));
    xfer(mode, DW'($urandom), DW'($urandom), 3, 1'b1, 1'b1, 1'b0, 1'b0, "both0");
    xfer(mode, DW'($urandom), DW'($urandom), 3, 1'b0, 1'b0, 1'b1, 1'b1, "both1");

    // Different slave requested during HOLD must wait for TRAIL to end.
    mode = 2'($urandom_range(0, 3));
    xfer(mode, DW'($urandom), DW'($urandom), 1, 1'b1, 1'b0, 1'b0, 1'b0, "mm0");
    d  = DW'($urandom);
    sw = DW'($urandom);
    drive(mode, d, 3, 1'b0, 1'b0);
    #1 chk("mm/ready_low", 32'(ready), 32'd0);
    repeat (5) @(posedge clk);
    #1 chk("mm/cs_unchanged", 32'(spi_cs_n), 32'hD);
    chk("mm/sclk_still", 32'(spi_sclk), 32'(mode[1]));
    @(negedge clk) release_burst = 1'b1;
    @(posedge clk); #1;
    release_burst = 1'b0;
    n = 0;
    while (spi_cs_n[3] !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mm/accept_delay", 32'(n), 32'(CD + 1));
    req = 1'b0;
    arm(mode, sw, 1'b0);
    finish(mode, d, sw, 3, 1'b0, 1'b0, 1'b0, "mm1");

    // Reset at SCLK edge 5 of a transfer.
    mode = 2'($urandom_range(0, 3));
    drive(mode, DW'($urandom), 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    arm(mode, DW'($urandom), 1'b0);
    n = 0;
    while (s_edges < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid/reached_edge5", 32'(s_edges), 32'd5);
    armed = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid/cs_n_async", 32'(spi_cs_n), 32'hF);
    chk("rstmid/sclk", 32'(spi_sclk), 32'd0);
    chk("rstmid/ready", 32'(ready), 32'd1);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 chk("rstmid/no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstmid/cs_idle", 32'(spi_cs_n), 32'hF);
    mode = 2'($urandom_range(0, 3));
    xfer(mode, DW'($urandom), DW'($urandom), 2, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
